// File: rtl/uni_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift right/left,
// parallel load, optional rotation and a saturating fill counter.
module uni_shift_reg #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   rotate,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH*DEPTH-1:0] pd,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       out_l,
    output logic [WIDTH*DEPTH-1:0] q,
    output logic [CW-1:0]          fill_cnt,
    output logic                   full
);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // Packed so that stage i occupies bits [WIDTH*i +: WIDTH], same as q and pd.
    logic [DEPTH-1:0][WIDTH-1:0] stg_p0, stg_nxt;
    logic [CW-1:0]               cnt_p0, cnt_nxt;
    logic                        full_p0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == CNT_MAX)
            return c;
        else
            return c + 1'b1;
    endfunction

    always_comb begin
        stg_nxt = stg_p0;
        cnt_nxt = cnt_p0;
        if (en) begin
            case (mode)
                M_RIGHT: begin
                    stg_nxt = {stg_p0[DEPTH-2:0], (rotate ? stg_p0[DEPTH-1] : d)};
                    if (!rotate)
                        cnt_nxt = sat_inc(cnt_p0);
                end
                M_LEFT: begin
                    stg_nxt = {(rotate ? stg_p0[0] : d), stg_p0[DEPTH-1:1]};
                    if (!rotate)
                        cnt_nxt = sat_inc(cnt_p0);
                end
                M_LOAD: begin
                    stg_nxt = pd;
                    cnt_nxt = CNT_MAX;
                end
                M_HOLD:  ;
                default: ;
            endcase
        end
    end

    // Stage 0: state registers; full is registered so every output is a plain flop tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_p0  <= '0;
            cnt_p0  <= '0;
            full_p0 <= 1'b0;
        end else begin
            stg_p0  <= stg_nxt;
            cnt_p0  <= cnt_nxt;
            full_p0 <= (cnt_nxt == CNT_MAX);
        end
    end

    assign q        = stg_p0;
    assign out      = stg_p0[DEPTH-1];
    assign out_l    = stg_p0[0];
    assign fill_cnt = cnt_p0;
    assign full     = full_p0;

endmodule

// File: tb/tb_uni_shift_reg.sv
// Bench for uni_shift_reg: two instances (WIDTH 1 and 8, DEPTH 4) checked against
// queue-based models every cycle, plus directed literal expectations.
module tb_uni_shift_reg;

    logic        clk = 1'b0;
    logic        rst, en, rotate;
    logic [1:0]  mode;
    logic        d1;
    logic [3:0]  pd1;
    logic [7:0]  d8;
    logic [31:0] pd8;

    logic        out1, outl1, full1;
    logic [3:0]  q1;
    logic [2:0]  fill1;
    logic [7:0]  out8, outl8;
    logic [31:0] q8;
    logic [2:0]  fill8;
    logic        full8;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    uni_shift_reg #(.WIDTH(1), .DEPTH(4)) u_n (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate),
        .d(d1), .pd(pd1), .out(out1), .out_l(outl1), .q(q1),
        .fill_cnt(fill1), .full(full1)
    );

    uni_shift_reg #(.WIDTH(8), .DEPTH(4)) u_w (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate),
        .d(d8), .pd(pd8), .out(out8), .out_l(outl8), .q(q8),
        .fill_cnt(fill8), .full(full8)
    );

    // Models: queue element 0 is stage 0; shift right pushes at the front.
    logic [7:0] mq1[$];
    logic [7:0] mq8[$];
    int         mc1, mc8;

    initial begin
        mq1 = '{8'h0, 8'h0, 8'h0, 8'h0};
        mq8 = '{8'h0, 8'h0, 8'h0, 8'h0};
        mc1 = 0;
        mc8 = 0;
    end

    always @(posedge clk) begin
        logic [7:0] t;
        if (rst) begin
            mq1 = '{8'h0, 8'h0, 8'h0, 8'h0};
            mq8 = '{8'h0, 8'h0, 8'h0, 8'h0};
            mc1 = 0;
            mc8 = 0;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    if (rotate) begin
                        t = mq1.pop_back(); mq1.push_front(t);
                        t = mq8.pop_back(); mq8.push_front(t);
                    end else begin
                        t = mq1.pop_back(); mq1.push_front({7'b0, d1});
                        t = mq8.pop_back(); mq8.push_front(d8);
                        mc1 = (mc1 + 1 > 4) ? 4 : mc1 + 1;
                        mc8 = (mc8 + 1 > 4) ? 4 : mc8 + 1;
                    end
                end
                2'b10: begin
                    if (rotate) begin
                        t = mq1.pop_front(); mq1.push_back(t);
                        t = mq8.pop_front(); mq8.push_back(t);
                    end else begin
                        t = mq1.pop_front(); mq1.push_back({7'b0, d1});
                        t = mq8.pop_front(); mq8.push_back(d8);
                        mc1 = (mc1 + 1 > 4) ? 4 : mc1 + 1;
                        mc8 = (mc8 + 1 > 4) ? 4 : mc8 + 1;
                    end
                end
                2'b11: begin
                    for (int i = 0; i < 4; i++) begin
                        mq1[i] = {7'b0, pd1[i]};
                        mq8[i] = pd8[8*i +: 8];
                    end
                    mc1 = 4;
                    mc8 = 4;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_q1",    {28'b0, q1}, {28'b0, mq1[3][0], mq1[2][0], mq1[1][0], mq1[0][0]});
            chk("model_out1",  {31'b0, out1},  {31'b0, mq1[3][0]});
            chk("model_outl1", {31'b0, outl1}, {31'b0, mq1[0][0]});
            chk("model_fill1", {29'b0, fill1}, 32'(mc1));
            chk("model_full1", {31'b0, full1}, {31'b0, (mc1 == 4)});
            chk("model_q8",    q8, {mq8[3], mq8[2], mq8[1], mq8[0]});
            chk("model_out8",  {24'b0, out8},  {24'b0, mq8[3]});
            chk("model_outl8", {24'b0, outl8}, {24'b0, mq8[0]});
            chk("model_fill8", {29'b0, fill8}, 32'(mc8));
            chk("model_full8", {31'b0, full8}, {31'b0, (mc8 == 4)});
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic ro,
                       input logic [7:0] dd, input logic [31:0] p);
        rst = r; en = e; mode = m; rotate = ro;
        d1 = dd[0]; d8 = dd; pd1 = p[3:0]; pd8 = p;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
    logic [3:0] rl_exp [4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
    int         f_exp  [5] = '{1, 2, 3, 4, 4};
    logic       o_exp  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] sl_d   [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; rotate = 1'b0;
        d1 = 1'b0; d8 = 8'h0; pd1 = 4'h0; pd8 = 32'h0;

        // Reset while load is requested with random data
        cyc(1'b1, 1'b1, 2'b11, 1'b0, 8'($urandom), $urandom);
        chk_on = 1'b1;
        cyc(1'b1, 1'b1, 2'b11, 1'b0, 8'($urandom), $urandom);
        chk("rst_q1",    {28'b0, q1}, 32'h0);
        chk("rst_out1",  {31'b0, out1}, 32'h0);
        chk("rst_fill1", {29'b0, fill1}, 32'h0);
        chk("rst_full1", {31'b0, full1}, 32'h0);
        chk("rst_q8",    q8, 32'h0);

        // SISO equivalence: a single 1 travels to out
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'h01, $urandom);
        chk("siso_fill_0", {29'b0, fill1}, 32'(f_exp[0]));
        chk("siso_out_0",  {31'b0, out1},  {31'b0, o_exp[0]});
        for (int i = 1; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, $urandom);
            chk($sformatf("siso_fill_%0d", i), {29'b0, fill1}, 32'(f_exp[i]));
            chk($sformatf("siso_out_%0d", i),  {31'b0, out1},  {31'b0, o_exp[i]});
        end
        chk("siso_full", {31'b0, full1}, 32'h1);

        // Load then rotate both ways
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 8'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'b11, 1'b0, 8'h0, 32'h0000_000B);
        chk("load_q1",    {28'b0, q1}, 32'hB);
        chk("load_full1", {31'b0, full1}, 32'h1);
        chk("load_outl1", {31'b0, outl1}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b01, 1'b1, 8'($urandom), $urandom);
            chk($sformatf("rotr_%0d", i), {28'b0, q1}, {28'b0, rr_exp[i]});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b10, 1'b1, 8'($urandom), $urandom);
            chk($sformatf("rotl_%0d", i), {28'b0, q1}, {28'b0, rl_exp[i]});
        end
        chk("rot_fill1", {29'b0, fill1}, 32'h4);

        // Shift left, 8-bit lanes
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 8'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 2'b10, 1'b0, sl_d[i], $urandom);
        chk("shl_outl8", {24'b0, outl8}, 32'hA1);
        chk("shl_q8",    q8, 32'hD4C3_B2A1);
        chk("shl_full8", {31'b0, full8}, 32'h1);
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 8'h5E, $urandom);
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 8'h6F, $urandom);
        chk("sat_fill8", {29'b0, fill8}, 32'h4);
        chk("sat_q8",    q8, 32'h6F5E_D4C3);

        // Hold via en = 0 and via mode 00
        cyc(1'b0, 1'b1, 2'b11, 1'b0, 8'h0, 32'h0000_0005);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 2'b01, 1'b0, 8'hFF, $urandom);
            chk($sformatf("hold_en_q_%0d", i),    {28'b0, q1}, 32'h5);
            chk($sformatf("hold_en_fill_%0d", i), {29'b0, fill1}, 32'h4);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, $urandom);
            chk($sformatf("hold_m0_q_%0d", i),    {28'b0, q1}, 32'h5);
            chk($sformatf("hold_m0_fill_%0d", i), {29'b0, fill1}, 32'h4);
        end
        cyc(1'b0, 1'b0, 2'b11, 1'b0, 8'h0, 32'h0000_000A);
        chk("noload_q1", {28'b0, q1}, 32'h5);

        // Reset in the middle of shifting
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 8'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'h1, $urandom);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'h1, $urandom);
        chk("pre_rst_q1", {28'b0, q1}, 32'h3);
        cyc(1'b1, 1'b1, 2'b01, 1'b0, 8'h1, $urandom);
        chk("mid_rst_q1",    {28'b0, q1}, 32'h0);
        chk("mid_rst_fill1", {29'b0, fill1}, 32'h0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 8'h1, $urandom);
        chk("post_rst_q1",    {28'b0, q1}, 32'h1);
        chk("post_rst_fill1", {29'b0, fill1}, 32'h1);
        cyc(1'b0, 1'b1, 2'b01, 1'b1, 8'h0, $urandom);
        chk("rot_nofill_fill1", {29'b0, fill1}, 32'h1);
        chk("rot_nofill_q1",    {28'b0, q1}, 32'h2);

        // Random traffic checked by the per-cycle model comparison
        for (int i = 0; i < 60; i++)
            cyc(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
                8'($urandom), $urandom);

        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
